// File: rtl/fifo_pkg.sv
// Shared defaults and operation decode for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 64;
    localparam int FIFO_ADDR_W = 6;
    localparam int FIFO_CNT_W  = 7;

    // Accepted operations on a given edge; bit 1 = write, bit 0 = read.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
        return fifo_op_e'({wr_acc, rd_acc});
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the control logic decides what is valid.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1<<ADDR_W];

    // Store the write word on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO: pointers, occupancy counter, flags and registered read data.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int CNT_W  = FIFO_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] buf_in,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic [CNT_W-1:0]  fifo_counter
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              wr_acc;
    logic              rd_acc;
    fifo_op_e          op;

    // Flags come straight off the counter, so they can never both be high.
    assign buf_empty = (fifo_counter == '0);
    assign buf_full  = (fifo_counter == CNT_W'(DEPTH));

    // Accept only what the current occupancy allows; nothing is accepted during reset,
    // which also keeps the memory write port quiet while rst is high.
    always_comb begin
        wr_acc = wr_en & ~buf_full & ~rst;
        rd_acc = rd_en & ~buf_empty & ~rst;
        op     = decode_op(wr_acc, rd_acc);
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (buf_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Pointers advance on accepted operations and wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_counter <= '0;
        end else begin
            case (op)
                OP_WR:   fifo_counter <= fifo_counter + CNT_W'(1);
                OP_RD:   fifo_counter <= fifo_counter - CNT_W'(1);
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    // Read data is registered and held until the next accepted read; no write bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         buf_out <= '0;
        else if (rd_acc) buf_out <= mem_rd_data;
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue-based reference model plus directed literal checks.
module tb_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] buf_in;
    logic [DATA_W-1:0] buf_out;
    logic              buf_empty;
    logic              buf_full;
    logic [CNT_W-1:0]  fifo_counter;

    int checks = 0;
    int errors = 0;

    fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_in       (buf_in),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored words and the last word read out.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_out = '0;
    bit                m_w;
    bit                m_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_out = '0;
        end else begin
            m_w = wr_en && (q.size() < DEPTH);
            m_r = rd_en && (q.size() > 0);
            if (m_r) m_out = q.pop_front();
            if (m_w) q.push_back(buf_in);
        end
    end

    // Every falling edge: DUT outputs must match the model.
    always @(negedge clk) begin
        checks++;
        if (fifo_counter !== CNT_W'(q.size()) || buf_empty !== (q.size() == 0) ||
            buf_full !== (q.size() == DEPTH) || buf_out !== m_out) begin
            errors++;
            $display("FAIL model_cmp t=%0t: cnt=%0d empty=%b full=%b out=%02h, want cnt=%0d empty=%b full=%b out=%02h",
                     $time, fifo_counter, buf_empty, buf_full, buf_out,
                     q.size(), (q.size() == 0), (q.size() == DEPTH), m_out);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns just after the rising edge.
    task automatic cyc(input logic w, input logic r, input logic [DATA_W-1:0] d);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'h01;

        // Reset holds everything at zero even with both requests high.
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_cnt",   int'(fifo_counter), 0);
        chk("rst_empty", int'(buf_empty), 1);
        chk("rst_full",  int'(buf_full), 0);
        chk("rst_out",   int'(buf_out), 0);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Write-then-read, with a read attempted on the first write while empty.
        cyc(1, 1, 8'h01);
        chk("wr_rd_empty_out", int'(buf_out), 0);
        cyc(1, 0, 8'h02);
        cyc(1, 0, 8'h03);
        chk("wtr_cnt3", int'(fifo_counter), 3);
        cyc(0, 1, 8'h00); chk("wtr_rd1", int'(buf_out), 8'h01);
        cyc(0, 1, 8'h00); chk("wtr_rd2", int'(buf_out), 8'h02);
        cyc(0, 1, 8'h00); chk("wtr_rd3", int'(buf_out), 8'h03);
        chk("wtr_cnt0",  int'(fifo_counter), 0);
        chk("wtr_empty", int'(buf_empty), 1);
        // Read while empty: output holds.
        cyc(0, 1, 8'h00);
        chk("rd_empty_hold", int'(buf_out), 8'h03);

        // Fill to full, then try to overfill.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(8'h10 + i));
        chk("fill_cnt",  int'(fifo_counter), 64);
        chk("fill_full", int'(buf_full), 1);
        cyc(1, 0, 8'h01); cyc(1, 0, 8'h02); cyc(1, 0, 8'h03);
        chk("overfill_cnt", int'(fifo_counter), 64);
        // Simultaneous at full: read only, oldest word out.
        cyc(1, 1, 8'hAA);
        chk("both_full_cnt", int'(fifo_counter), 63);
        chk("both_full_out", int'(buf_out), 8'h10);
        for (int i = 1; i < DEPTH; i++) begin
            cyc(0, 1, 8'h00);
            chk("drain_out", int'(buf_out), 8'h10 + i);
        end
        chk("drain_empty", int'(buf_empty), 1);

        // Simultaneous at occupancy 10.
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'hC0 + i));
        cyc(1, 1, 8'hCA);
        chk("both_10_cnt", int'(fifo_counter), 10);
        chk("both_10_out", int'(buf_out), 8'hC0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 8'h00);
            chk("both_10_drain", int'(buf_out), 8'hC0 + i);
        end
        chk("both_10_cnt0", int'(fifo_counter), 0);

        // Wrap-around: three rounds of 40 writes / 40 reads crosses the pointer wrap.
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 40; i++) cyc(1, 0, 8'(rep * 40 + i));
            chk("wrap_cnt40", int'(fifo_counter), 40);
            for (int i = 0; i < 40; i++) begin
                cyc(0, 1, 8'h00);
                chk("wrap_out", int'(buf_out), (rep * 40 + i) & 8'hFF);
            end
            chk("wrap_cnt0", int'(fifo_counter), 0);
        end

        // Asynchronous reset between edges at occupancy 20.
        for (int i = 0; i < 21; i++) cyc(1, 0, 8'(8'h50 + i));
        cyc(0, 1, 8'h00);
        chk("pre_arst_cnt", int'(fifo_counter), 20);
        chk("pre_arst_out", int'(buf_out), 8'h50);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt",   int'(fifo_counter), 0);
        chk("arst_empty", int'(buf_empty), 1);
        chk("arst_full",  int'(buf_full), 0);
        chk("arst_out",   int'(buf_out), 0);
        @(posedge clk); #1 rst = 1'b0;
        // Stored data is gone: a read after reset is ignored.
        cyc(0, 1, 8'h00);
        chk("post_arst_out", int'(buf_out), 0);
        cyc(1, 0, 8'h77);
        cyc(0, 1, 8'h00);
        chk("post_arst_rd", int'(buf_out), 8'h77);
        cyc(0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored word.
REQ-002 Parameter DEPTH, default 64: number of storage entries; power of two.
REQ-003 Parameter CNT_W, default 7: occupancy counter width, equal to log2(DEPTH)+1.
REQ-004 clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 wr_en  input  1: write request.
REQ-007 rd_en  input  1: read request.
REQ-008 buf_in  input  DATA_W: write data, sampled on the rising edge when a write is accepted.
REQ-009 buf_out  output  DATA_W: registered read data.
REQ-010 buf_empty  output  1: high when occupancy is 0.
REQ-011 buf_full  output  1: high when occupancy equals DEPTH.
REQ-012 fifo_counter  output  CNT_W: current occupancy, range 0..DEPTH.

Function
REQ-013 The block SHALL accept a write when wr_en=1 and buf_full=0.
- Accepted write: buf_in is stored at the write pointer and the write pointer increments modulo DEPTH.
REQ-014 The block SHALL accept a read when rd_en=1 and buf_empty=0.
- Accepted read: buf_out loads the entry at the read pointer on that edge (1-cycle latency) and the read pointer increments modulo DEPTH.
REQ-015 buf_out SHALL hold its previous value on every cycle without an accepted read.
REQ-016 fifo_counter SHALL change only on accepted operations:
- accepted write only: +1
- accepted read only: -1
- both accepted: unchanged
- neither accepted: unchanged
REQ-017 Write while full SHALL be dropped: no change to memory, pointer or counter.
REQ-018 Read while empty SHALL be ignored: buf_out and the read pointer are unchanged.
REQ-019 wr_en=rd_en=1 while empty SHALL perform the write only (counter +1); the new word is not bypassed to buf_out.
REQ-020 wr_en=rd_en=1 while full SHALL perform the read only (counter -1); the write data is discarded.
REQ-021 buf_empty and buf_full SHALL be decoded combinationally from fifo_counter (==0, ==DEPTH) and SHALL never be high together.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering; data SHALL exit in strict write order.
REQ-023 fifo_counter SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for a clock edge, force:
- fifo_counter = 0, buf_empty = 1, buf_full = 0
- buf_out = 0
- both pointers = 0
REQ-025 Memory contents need not be cleared; after reset the stored data is treated as invalid.
REQ-026 While rst is high, wr_en and rd_en SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard all stored data.

Structure
REQ-028 A shared package fifo_pkg SHALL hold the defaults DATA_W=8, DEPTH=64, ADDR_W=6 and CNT_W=7.
REQ-029 Storage SHALL be a sub-module fifo_mem: a simple dual-port array with one synchronous write port and one read port.
REQ-030 Pointer, counter and flag logic SHALL reside in fifo.

Verification
REQ-031 Reset check: rst=1 with wr_en=rd_en=1 and buf_in=0x01 -> counter=0, empty=1, full=0, buf_out=0x00.
REQ-032 Write-then-read: write 0x01, 0x02, 0x03 (rd_en=1 during the first write, while empty) -> counter=3; three reads return 0x01, 0x02, 0x03, then counter=0 and empty=1.
REQ-033 Fill to full: 64 consecutive writes from empty -> counter=64, full=1.
- Further writes (e.g. 0x01, 0x02, 0x03) are dropped; counter stays 64.
- Draining returns the first 64 values in order.
REQ-034 Wrap-around: repeated write 40 / read 40 cycles -> ordering preserved across the pointer wrap; counter returns to 0.
REQ-035 Simultaneous operations:
- wr_en=rd_en=1 at occupancy 10 -> counter stays 10.
- at full -> counter 63 and the oldest word appears on buf_out.
REQ-036 Asynchronous reset: assert rst between clock edges at occupancy 20 -> counter=0, empty=1 and buf_out=0 before the next edge.
